// File: rtl/rsa_req_sequencer_pkg.sv
// Shared definitions for the rsa4k request sequencer: default widths,
// FSM state encoding and operand segment encoding.
package rsa_pkg;

    localparam int WIDTH_DEF = 4096;
    localparam int WORD_DEF  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_SEND    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEG_MOD = 2'd0,
        SEG_EXP = 2'd1,
        SEG_MSG = 2'd2
    } seg_e;

    // Operands arrive modulus first, then exponent, then message.
    function automatic seg_e next_seg(input seg_e s);
        seg_e n;
        case (s)
            SEG_MOD: n = SEG_EXP;
            SEG_EXP: n = SEG_MSG;
            default: n = SEG_MSG;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rsa_req_sequencer_if.sv
// Word-stream interface of the sequencer: operand input stream and
// result output stream, each with a valid/ready handshake.
interface rsa_req_sequencer_if #(
    parameter int WORD = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [WORD-1:0] in_data;
    logic            keep_key;
    logic            out_valid;
    logic            out_ready;
    logic [WORD-1:0] out_data;
    logic            out_last;

    modport master (
        output in_valid, in_data, keep_key, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, keep_key, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rsa_req_sequencer_word_shifter.sv
// WIDTH-bit register with an indexed WORD-lane write and a full-width load;
// holds one operand or the captured result.
module rsa_word_shifter #(
    parameter int WIDTH = 4096,
    parameter int WORD  = 32,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WORD-1:0]  wr_data,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] q
);

    // Register update: full load wins over a lane write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= {WIDTH{1'b0}};
        end else if (ld_en) begin
            q <= ld_data;
        end else if (wr_en) begin
            q[int'(wr_idx)*WORD +: WORD] <= wr_data;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/rsa_req_sequencer.sv
// Host-side initiator for the rsa4k core: loads operands from a word stream,
// runs the go/done handshake, and streams the captured result back out.
module rsa_req_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int WORD  = WORD_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    rsa_req_sequencer_if.slave   strm,
    output logic                 busy,
    output logic                 core_go,
    output logic [WIDTH-1:0]     core_message,
    output logic [WIDTH-1:0]     core_exponent,
    output logic [WIDTH-1:0]     core_modulus,
    input  logic                 core_done,
    input  logic [WIDTH-1:0]     core_cypher
);

    localparam int N     = WIDTH / WORD;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_e           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    seg_e             seg_r, seg_s;
    seg_e             first_seg_s, wr_seg_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic             in_fire_s, out_fire_s, res_ld_s;
    logic             mod_we_s, exp_we_s, msg_we_s;
    logic [WIDTH-1:0] result_q_s;
    logic [WORD-1:0]  rd_word_s;

    logic             in_ready_r, busy_r, core_go_r;
    logic             out_valid_r, out_last_r;
    logic [WORD-1:0]  out_data_r;

    assign in_fire_s   = strm.in_valid && in_ready_r;
    assign out_fire_s  = out_valid_r && strm.out_ready;
    assign first_seg_s = strm.keep_key ? SEG_MSG : SEG_MOD;

    // Next-state, counter and write-target decode.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        seg_s    = seg_r;
        wr_seg_s = seg_r;
        wr_idx_s = idx_r;
        res_ld_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wr_seg_s = first_seg_s;
                wr_idx_s = IDX_ZERO;
                if (in_fire_s) begin
                    if (IDX_LAST == IDX_ZERO) begin
                        idx_s = IDX_ZERO;
                        if (first_seg_s == SEG_MSG) begin
                            state_s = ST_RUN;
                        end else begin
                            seg_s   = next_seg(first_seg_s);
                            state_s = ST_LOAD;
                        end
                    end else begin
                        idx_s   = IDX_ONE;
                        seg_s   = first_seg_s;
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_fire_s) begin
                    if (idx_r == IDX_LAST) begin
                        idx_s = IDX_ZERO;
                        if (seg_r == SEG_MSG) begin
                            state_s = ST_RUN;
                        end else begin
                            seg_s = next_seg(seg_r);
                        end
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    res_ld_s = 1'b1;
                    state_s  = ST_RELEASE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            // A done still high from this job must never complete the next one.
            ST_RELEASE: begin
                if (!core_done) begin
                    state_s = ST_SEND;
                    idx_s   = IDX_ZERO;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            ST_SEND: begin
                if (out_fire_s) begin
                    if (idx_r == IDX_LAST) begin
                        state_s = ST_IDLE;
                        idx_s   = IDX_ZERO;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = IDX_ZERO;
                seg_s   = SEG_MOD;
            end
        endcase
    end

    assign mod_we_s  = in_fire_s && (wr_seg_s == SEG_MOD);
    assign exp_we_s  = in_fire_s && (wr_seg_s == SEG_EXP);
    assign msg_we_s  = in_fire_s && (wr_seg_s == SEG_MSG);
    assign rd_word_s = result_q_s[int'(idx_s)*WORD +: WORD];

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
            seg_r   <= SEG_MOD;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            seg_r   <= seg_s;
        end
    end

    // Registered outputs derived from the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            core_go_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {WORD{1'b0}};
        end else begin
            in_ready_r  <= (state_s == ST_IDLE) || (state_s == ST_LOAD);
            busy_r      <= (state_s != ST_IDLE);
            core_go_r   <= (state_s == ST_RUN);
            out_valid_r <= (state_s == ST_SEND);
            out_last_r  <= (state_s == ST_SEND) && (idx_s == IDX_LAST);
            out_data_r  <= (state_s == ST_SEND) ? rd_word_s : {WORD{1'b0}};
        end
    end

    rsa_word_shifter #(.WIDTH(WIDTH), .WORD(WORD), .IDX_W(IDX_W)) u_mod (
        .clk(clk), .reset(reset), .wr_en(mod_we_s), .wr_idx(wr_idx_s),
        .wr_data(strm.in_data), .ld_en(1'b0), .ld_data({WIDTH{1'b0}}),
        .q(core_modulus)
    );

    rsa_word_shifter #(.WIDTH(WIDTH), .WORD(WORD), .IDX_W(IDX_W)) u_exp (
        .clk(clk), .reset(reset), .wr_en(exp_we_s), .wr_idx(wr_idx_s),
        .wr_data(strm.in_data), .ld_en(1'b0), .ld_data({WIDTH{1'b0}}),
        .q(core_exponent)
    );

    rsa_word_shifter #(.WIDTH(WIDTH), .WORD(WORD), .IDX_W(IDX_W)) u_msg (
        .clk(clk), .reset(reset), .wr_en(msg_we_s), .wr_idx(wr_idx_s),
        .wr_data(strm.in_data), .ld_en(1'b0), .ld_data({WIDTH{1'b0}}),
        .q(core_message)
    );

    rsa_word_shifter #(.WIDTH(WIDTH), .WORD(WORD), .IDX_W(IDX_W)) u_res (
        .clk(clk), .reset(reset), .wr_en(1'b0), .wr_idx(IDX_ZERO),
        .wr_data({WORD{1'b0}}), .ld_en(res_ld_s), .ld_data(core_cypher),
        .q(result_q_s)
    );

    assign strm.in_ready  = in_ready_r;
    assign strm.out_valid = out_valid_r;
    assign strm.out_last  = out_last_r;
    assign strm.out_data  = out_data_r;
    assign busy           = busy_r;
    assign core_go        = core_go_r;

endmodule

// File: tb/tb_rsa_req_sequencer.sv
// Bench for rsa_req_sequencer at WIDTH=64/WORD=16 with a behavioural
// modexp core and an operand/key reference model.
module tb_rsa_req_sequencer;

    localparam int WIDTH = 64;
    localparam int WORD  = 16;
    localparam int N     = WIDTH / WORD;
    localparam int DONE_DELAY = 5;

    logic             clk;
    logic             reset;
    logic             busy;
    logic             core_go;
    logic [WIDTH-1:0] core_message, core_exponent, core_modulus;
    logic             core_done;
    logic [WIDTH-1:0] core_cypher;

    int checks = 0;
    int errors = 0;
    int hold_cfg = 0;
    int hold_left = 0;
    int go_cnt = 0;
    logic [63:0] model_mod = 64'd0;
    logic [63:0] model_exp = 64'd0;

    rsa_req_sequencer_if #(.WORD(WORD)) strm ();

    rsa_req_sequencer #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk(clk), .reset(reset), .strm(strm), .busy(busy),
        .core_go(core_go), .core_message(core_message),
        .core_exponent(core_exponent), .core_modulus(core_modulus),
        .core_done(core_done), .core_cypher(core_cypher)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] m);
        logic [127:0] r, x, mm;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        x  = {64'd0, b} % mm;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[63:0];
    endfunction

    // Behavioural core: done rises DONE_DELAY cycles after go, holds until go
    // falls and then for hold_cfg further cycles.
    always @(posedge clk) begin
        if (!reset) begin
            core_done   <= 1'b0;
            core_cypher <= 64'd0;
            go_cnt      <= 0;
            hold_left   <= 0;
        end else if (core_go) begin
            if (!core_done) begin
                if (go_cnt == DONE_DELAY - 1) begin
                    core_done   <= 1'b1;
                    core_cypher <= modexp(core_message, core_exponent, core_modulus);
                    hold_left   <= hold_cfg;
                end
                go_cnt <= go_cnt + 1;
            end
        end else begin
            go_cnt <= 0;
            if (core_done) begin
                if (hold_left == 0) core_done <= 1'b0;
                else hold_left <= hold_left - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {59'd0, strm.in_ready, strm.out_valid, strm.out_last, core_go, busy}, 64'd0);
        check({tag, "_data"}, {48'd0, strm.out_data}, 64'd0);
        check({tag, "_ops"}, core_modulus | core_exponent | core_message, 64'd0);
    endtask

    task automatic push_word(input logic [15:0] w, input logic kk, input bit gaps,
                             output int waits, output bit taken);
        int guard;
        waits = 0; taken = 1'b0; guard = 0;
        for (int g = 0; g < 3 && gaps && $urandom_range(0, 2) == 0; g++) begin
            strm.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        strm.in_valid = 1'b1; strm.in_data = w; strm.keep_key = kk;
        while (!taken && guard < 200) begin
            taken = (strm.in_ready === 1'b1);
            @(posedge clk); #1;
            if (!taken) begin waits++; guard++; end
        end
        strm.in_valid = 1'b0;
        strm.keep_key = 1'($urandom_range(0, 1));
    endtask

    task automatic push_job(input logic kk, input logic [63:0] m, input logic [63:0] e,
                            input logic [63:0] msg, input bit gaps,
                            output int accepted, output int first_waits);
        logic [63:0] val;
        int w; bit t; bit first;
        accepted = 0; first = 1'b1; first_waits = 0;
        if (!kk) begin model_mod = m; model_exp = e; end
        for (int s = (kk ? 2 : 0); s < 3; s++) begin
            val = (s == 0) ? m : ((s == 1) ? e : msg);
            for (int i = 0; i < N; i++) begin
                push_word(val[i*WORD +: WORD], first ? kk : 1'($urandom_range(0, 1)), gaps, w, t);
                if (first) first_waits = w;
                first = 1'b0;
                if (t) accepted++;
            end
        end
    endtask

    task automatic pull_result(input logic [63:0] expv, input bit stalls);
        int got, guard; logic [15:0] prev; bit prev_stalled, xfer;
        got = 0; guard = 0; prev = 16'd0; prev_stalled = 1'b0;
        while (got < N && guard < 500) begin
            if (core_done === 1'b1) check("valid_while_done", {63'd0, strm.out_valid}, 64'd0);
            if (strm.out_valid === 1'b1) begin
                check("out_data", {48'd0, strm.out_data}, {48'd0, expv[got*WORD +: WORD]});
                check("out_last", {63'd0, strm.out_last}, {63'd0, (got == N - 1)});
                check("in_ready_send", {63'd0, strm.in_ready}, 64'd0);
                if (prev_stalled) check("stall_stable", {48'd0, strm.out_data}, {48'd0, prev});
            end
            strm.out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            xfer = (strm.out_valid === 1'b1) && strm.out_ready;
            prev = strm.out_data;
            prev_stalled = (strm.out_valid === 1'b1) && !strm.out_ready;
            @(posedge clk); #1;
            guard++;
            if (xfer) got++;
        end
        strm.out_ready = 1'b0;
        check("out_words", 64'(got), 64'(N));
        check("idle_after", {61'd0, busy, strm.out_valid, strm.in_ready}, 64'd1);
    endtask

    task automatic run_job(input logic kk, input logic [63:0] m, input logic [63:0] e,
                           input logic [63:0] msg, input bit use_kat, input logic [63:0] kat,
                           input int hold, input bit gaps, input bit stalls,
                           output int first_waits);
        int acc;
        logic [63:0] expv;
        hold_cfg = hold;
        push_job(kk, m, e, msg, gaps, acc, first_waits);
        expv = use_kat ? kat : modexp(msg, model_exp, model_mod);
        check("in_words", 64'(acc), kk ? 64'(N) : 64'(3 * N));
        check("go_latency", {63'd0, core_go}, 64'd1);
        check("ready_run", {62'd0, strm.in_ready, busy}, 64'd1);
        check("op_mod", core_modulus, model_mod);
        check("op_exp", core_exponent, model_exp);
        check("op_msg", core_message, msg);
        pull_result(expv, stalls);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fw, acc, w;
        bit t;
        logic [63:0] m, e, msg;
        reset = 1'b0;
        strm.in_valid = 1'b0; strm.in_data = 16'd0; strm.keep_key = 1'b0;
        strm.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {62'd0, strm.in_ready, busy}, 64'd2);

        // Known-answer encrypt/decrypt, then key reuse; the keep_key job
        // starts in the cycle right after the previous job's last output.
        run_job(1'b0, 64'd77, 64'd13, 64'd8, 1'b1, 64'd50, 0, 1'b0, 1'b0, fw);
        run_job(1'b0, 64'd77, 64'd37, 64'd50, 1'b1, 64'd8, 0, 1'b0, 1'b0, fw);
        run_job(1'b1, 64'd0, 64'd0, 64'd50, 1'b1, 64'd8, 0, 1'b0, 1'b0, fw);
        check("b2b_first_word", 64'(fw), 64'd0);

        // Randomised jobs with input gaps, output stalls and lingering done.
        for (int j = 0; j < 6; j++) begin
            m   = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
            e   = {$urandom, $urandom};
            msg = {$urandom, $urandom};
            run_job((j > 0) ? 1'($urandom_range(0, 1)) : 1'b0, m, e, msg, 1'b0, 64'd0,
                    $urandom_range(0, 3), 1'b1, 1'b1, fw);
        end
        run_job(1'b0, {$urandom, $urandom} | 64'h8000_0000_0000_0001, {$urandom, $urandom},
                {$urandom, $urandom}, 1'b0, 64'd0, 3, 1'b0, 1'b1, fw);

        // Reset during EXP word 2 of a load.
        for (int i = 0; i < N + 2; i++) push_word(16'($urandom), 1'b0, 1'b0, w, t);
        strm.in_valid = 1'b1; strm.in_data = 16'hBEEF; reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; strm.in_valid = 1'b0;
        check_all_zero("reset_load");
        model_mod = 64'd0; model_exp = 64'd0;
        run_job(1'b0, 64'hF123_4567_89AB_CDEF, 64'h0000_0000_0001_0001, 64'h1234_5678_9ABC_DEF0,
                1'b0, 64'd0, 1, 1'b1, 1'b1, fw);

        // Reset while the core is running.
        hold_cfg = 0;
        push_job(1'b0, 64'hC000_0000_0000_0035, 64'd65537, 64'h0BAD_CAFE_1234_5678, 1'b0, acc, fw);
        repeat (2) @(posedge clk);
        #1;
        check("go_held", {63'd0, core_go}, 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_all_zero("reset_run");
        model_mod = 64'd0; model_exp = 64'd0;
        run_job(1'b0, 64'hC000_0000_0000_0035, 64'd65537, 64'h0BAD_CAFE_1234_5678,
                1'b0, 64'd0, 2, 1'b1, 1'b1, fw);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
